// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave: byte-lane writes, two-cycle classic reads and
// registered-feedback incrementing bursts when WB_BRAM_BURST_EN is defined.
module wb_bram_burst #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADR_WIDTH     = 32,
  parameter int unsigned MEM_ADR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADR_WIDTH-1:0]    adr,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic                    we,
  input  logic                    stb,
  input  logic                    cyc,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic                    ack,
  output logic                    err,
  output logic                    rty
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LSB       = $clog2(SEL_WIDTH);
  localparam int unsigned DEPTH     = 1 << MEM_ADR_WIDTH;

`ifdef WB_BRAM_BURST_EN
  typedef enum logic [1:0] {IDLE, RD, BURST} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD} state_t;
`endif

  state_t                   state, state_n;
  logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0]    dat_q;
  logic [MEM_ADR_WIDTH-1:0] radr;
  logic [MEM_ADR_WIDTH-1:0] widx;
  logic [MEM_ADR_WIDTH-1:0] ld_idx;
  logic                     ld;
  logic                     oor;
  logic                     req;
  logic                     rd_req;
  logic                     wr_req;
  logic                     err_c;
  logic                     ack_rd;
  logic                     unused_bits;

  assign widx   = adr[MEM_ADR_WIDTH+LSB-1:LSB];
  assign oor    = (adr >> (MEM_ADR_WIDTH + LSB)) != '0;
  assign req    = cyc & stb;
  assign err_c  = req & oor;
  assign wr_req = req & we & ~oor;
  assign rd_req = req & ~we & ~oor;

`ifdef WB_BRAM_BURST_EN
  // Wrap bursts only advance the low 2/3/4 bits; linear wraps at memory depth.
  function automatic logic [MEM_ADR_WIDTH-1:0] nxt(
    input logic [MEM_ADR_WIDTH-1:0] w,
    input logic [1:0]               b
  );
    logic [MEM_ADR_WIDTH-1:0] inc;
    inc = w + MEM_ADR_WIDTH'(1);
    case (b)
      2'b01:   nxt = {w[MEM_ADR_WIDTH-1:2], inc[1:0]};
      2'b10:   nxt = {w[MEM_ADR_WIDTH-1:3], inc[2:0]};
      2'b11:   nxt = {w[MEM_ADR_WIDTH-1:4], inc[3:0]};
      default: nxt = inc;
    endcase
  endfunction

  assign unused_bits = ^adr[LSB-1:0];
`else
  assign unused_bits = ^{adr[LSB-1:0], cti, bte, radr};
`endif

  always_comb begin
    state_n = state;
    ack_rd  = 1'b0;
    ld      = 1'b0;
    ld_idx  = widx;
    case (state)
      IDLE: begin
        if (rd_req) begin
          ld      = 1'b1;
          state_n = RD;
        end
      end
      RD: begin
        ack_rd  = rd_req;
        state_n = IDLE;
`ifdef WB_BRAM_BURST_EN
        if (rd_req && cti == 3'b010) begin
          ld      = 1'b1;
          ld_idx  = nxt(widx, bte);
          state_n = BURST;
        end
      end
      BURST: begin
        // The prefetched word is only valid if the master kept to the sequence.
        if (rd_req) begin
          if (widx == radr) begin
            ack_rd = 1'b1;
            if (cti == 3'b010) begin
              ld     = 1'b1;
              ld_idx = nxt(widx, bte);
            end else begin
              state_n = IDLE;
            end
          end else begin
            ld      = 1'b1;
            state_n = RD;
          end
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    if (!cyc || err_c) begin
      state_n = IDLE;
      ld      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      radr  <= '0;
      dat_q <= '0;
    end else begin
      state <= state_n;
      if (ld) begin
        radr  <= ld_idx;
        dat_q <= mem[ld_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < SEL_WIDTH; k++) begin
      if (wr_req && !rst && sel[k]) mem[widx][k*8 +: 8] <= dat_ms[k*8 +: 8];
    end
  end

  assign dat_sm = dat_q;
  assign ack    = ~rst & (wr_req | ack_rd);
  assign err    = ~rst & err_c;
  assign rty    = 1'b0;

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed self-checking bench for wb_bram_burst; expected burst timing follows
// whether WB_BRAM_BURST_EN is defined for the build.
module tb_wb_bram_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_w [4];
  int unsigned exp_c [4];
  logic [31:0] exp_d [4];

  wb_bram_burst #(
    .DATA_WIDTH   (32),
    .ADR_WIDTH    (32),
    .MEM_ADR_WIDTH(11)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .adr   (adr),
    .dat_ms(dat_ms),
    .dat_sm(dat_sm),
    .sel   (sel),
    .we    (we),
    .stb   (stb),
    .cyc   (cyc),
    .cti   (cti),
    .bte   (bte),
    .ack   (ack),
    .err   (err),
    .rty   (rty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                       input logic [1:0] bt);
    cyc = c; stb = s; we = w; adr = a; dat_ms = d; sel = sl; cti = ct; bte = bt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Registered-feedback master: advances to the next beat only after an ack.
  task automatic burst(input string tag, input int unsigned nb, input logic [1:0] bt,
                       input int unsigned wait_after);
    int unsigned k = 0;
    int unsigned n = 0;
    logic hold = 1'b0;
    while (k < nb && n < 32) begin
      drive(1'b1, ~hold, 1'b0, 32'(exp_w[k] * 4), '0, 4'hF,
            (k == nb - 1) ? 3'b111 : 3'b010, bt);
      @(negedge clk);
      if (ack) begin
        check({tag, "_cyc"}, 64'(n), 64'(exp_c[k]));
        check({tag, "_dat"}, 64'(dat_sm), 64'(exp_d[k]));
        k++;
        hold = (k == wait_after);
      end else begin
        hold = 1'b0;
      end
      next_cycle();
      n++;
    end
    check({tag, "_beats"}, 64'(k), 64'(nb));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rty", 64'(rty), 64'(0));
    check("rst_dat", 64'(dat_sm), 64'(0));
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF, 3'b000, 2'b00);
      @(negedge clk);
      check("fill_ack", 64'(ack), 64'(1));
      next_cycle();
    end

    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    check("wr_full_ack", 64'(ack), 64'(1));
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 3'b000, 2'b00);
    @(negedge clk);
    check("wr_lane_ack", 64'(ack), 64'(1));
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h10, '0, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    check("rd10_ack_n", 64'(ack), 64'(0));
    next_cycle();
    @(negedge clk);
    check("rd10_ack_n1", 64'(ack), 64'(1));
    check("rd10_dat", 64'(dat_sm), 64'(32'hDEAD_BEAA));
    next_cycle();
    idle();
    next_cycle();

    drive(1'b1, 1'b1, 1'b0, 32'h0, '0, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    check("b2b_ack0", 64'(ack), 64'(0));
    next_cycle();
    @(negedge clk);
    check("b2b_ack1", 64'(ack), 64'(1));
    check("b2b_dat0", 64'(dat_sm), 64'(32'hC000_0000));
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h4, '0, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    check("b2b_ack2", 64'(ack), 64'(0));
    next_cycle();
    @(negedge clk);
    check("b2b_ack3", 64'(ack), 64'(1));
    check("b2b_dat1", 64'(dat_sm), 64'(32'hC000_0001));
    next_cycle();
    idle();
    next_cycle();

    exp_w = '{8, 9, 10, 11};
    exp_d = '{32'hC000_0008, 32'hC000_0009, 32'hC000_000A, 32'hC000_000B};
`ifdef WB_BRAM_BURST_EN
    exp_c = '{1, 2, 3, 4};
`else
    exp_c = '{1, 3, 5, 7};
`endif
    burst("lin", 4, 2'b00, 0);
    // Word 12 is what a lingering burst would have prefetched; IDLE must not ack it at once.
    drive(1'b1, 1'b1, 1'b0, 32'h30, '0, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    check("lin_idle_ack", 64'(ack), 64'(0));
    next_cycle();
    @(negedge clk);
    check("lin_after_ack", 64'(ack), 64'(1));
    check("lin_after_dat", 64'(dat_sm), 64'(32'hC000_000C));
    next_cycle();
    idle();
    next_cycle();

    exp_w = '{6, 7, 4, 5};
    exp_d = '{32'hC000_0006, 32'hC000_0007, 32'hDEAD_BEAA, 32'hC000_0005};
`ifdef WB_BRAM_BURST_EN
    exp_c = '{1, 2, 4, 5};
`else
    exp_c = '{1, 3, 6, 8};
`endif
    burst("wrap4", 4, 2'b01, 2);
    idle();
    next_cycle();

    drive(1'b1, 1'b1, 1'b0, 32'h2000, '0, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    check("oor_rd_err", 64'(err), 64'(1));
    check("oor_rd_ack", 64'(ack), 64'(0));
    next_cycle();
    @(negedge clk);
    check("oor_rd_err2", 64'(err), 64'(1));
    check("oor_rd_ack2", 64'(ack), 64'(0));
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    check("oor_wr_err", 64'(err), 64'(1));
    check("oor_wr_ack", 64'(ack), 64'(0));
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h0, '0, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    check("oor_chk_err", 64'(err), 64'(0));
    next_cycle();
    @(negedge clk);
    check("oor_chk_ack", 64'(ack), 64'(1));
    check("oor_chk_dat", 64'(dat_sm), 64'(32'hC000_0000));
    next_cycle();
    idle();
    next_cycle();

    drive(1'b1, 1'b1, 1'b0, 32'h20, '0, 4'hF, 3'b010, 2'b00);
    @(negedge clk);
    check("mrst_req_ack", 64'(ack), 64'(0));
    next_cycle();
    @(negedge clk);
    check("mrst_b1_ack", 64'(ack), 64'(1));
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h24, '0, 4'hF, 3'b010, 2'b00);
`ifndef WB_BRAM_BURST_EN
    @(negedge clk);
    check("mrst_b2_req", 64'(ack), 64'(0));
    next_cycle();
`endif
    rst = 1'b1;
    @(negedge clk);
    check("mrst_ack", 64'(ack), 64'(0));
    check("mrst_dat", 64'(dat_sm), 64'(0));
    check("mrst_err", 64'(err), 64'(0));
    next_cycle();
    rst = 1'b0;
    idle();
    next_cycle();

    drive(1'b1, 1'b1, 1'b0, 32'h24, '0, 4'hF, 3'b000, 2'b00);
    next_cycle();
    @(negedge clk);
    check("post_rst_ack", 64'(ack), 64'(1));
    check("post_rst_dat", 64'(dat_sm), 64'(32'hC000_0009));
    next_cycle();
    idle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
